// File: rtl/instruction_loader.sv
// instruction_loader: loads a program into instruction memory from a byte
// stream while holding the CPU in reset. The stream is a 2-byte little-endian
// word count followed by the program bytes, packed into 32-bit little-endian
// words, one memory write per word.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the program data.
`timescale 1ns/1ps
module instruction_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd5;
`endif

    // A header larger than this many words cannot fit in memory
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [15:0]           r_count;
    logic [ADDR_WIDTH:0]   r_word_idx;     // one extra bit so a full load does not wrap
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_word_buf;     // bytes 0..2 of the word being assembled
    logic                  r_imem_we;
    logic [31:0]           r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            r_xor;
`endif

    logic                  w_byte_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_idx_next;
    logic [15:0]           w_hdr_count;
    logic                  w_oversize;
    logic                  w_last_word;

`ifdef LOADER_CHECKSUM_EN
    assign w_byte_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                          (r_state == S_DATA) || (r_state == S_CHECK);
`else
    assign w_byte_ready = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                          (r_state == S_DATA);
`endif

    assign w_accept    = byte_valid && w_byte_ready;
    assign w_idx_next  = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign w_hdr_count = {byte_in, r_count[7:0]};
    assign w_oversize  = {16'd0, w_hdr_count} > CAPACITY;
    assign w_last_word = 32'(w_idx_next) == {16'd0, r_count};

    // Loader FSM: header parse, word assembly, memory write, completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= 16'd0;
            r_word_idx   <= '0;
            r_byte_idx   <= 2'd0;
            r_word_buf   <= 24'd0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= 32'd0;
            r_imem_wdata <= 32'd0;
            r_cpu_hold   <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
`endif
        end else begin
            // Strobes are single-cycle unless a state below re-asserts them
            r_imem_we <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_HDR0;
                        r_error    <= 1'b0;
                        r_word_idx <= '0;
                        r_byte_idx <= 2'd0;
                        r_cpu_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor      <= 8'd0;
`endif
                    end
                end
                S_HDR0: begin
                    if (w_accept) begin
                        r_count[7:0] <= byte_in;
                        r_state      <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_count[15:8] <= byte_in;
                        if (w_hdr_count == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state <= S_CHECK;
`else
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
`endif
                        end else if (w_oversize) begin
                            r_error <= 1'b1;
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ byte_in;
`endif
                        case (r_byte_idx)
                            2'd0: r_word_buf[7:0]   <= byte_in;
                            2'd1: r_word_buf[15:8]  <= byte_in;
                            2'd2: r_word_buf[23:16] <= byte_in;
                            default: begin
                                // Fourth byte completes the word: present it next cycle
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= 32'({r_word_idx[ADDR_WIDTH-1:0], 2'b00});
                                r_imem_wdata <= {byte_in, r_word_buf};
                                r_state      <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_next;
                    if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_state <= S_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        if (byte_in != r_xor) begin
                            r_error <= 1'b1;
                        end
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end
                end
`endif
                S_FIN: begin
                    r_cpu_hold <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = w_byte_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_hold   = r_cpu_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader (ADDR_WIDTH=2, capacity 4 words).
// Stimulus pushes expected memory writes into a queue; a negedge monitor pops
// and compares each write the loader issues.
`timescale 1ns/1ps
module tb_instruction_loader;
    localparam int AW  = 2;
    localparam int CAP = 4;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    logic [63:0] exp_q[$];   // {addr, data}
    logic [7:0]  prog_q[$];  // program bytes for the next load

    instruction_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every write must match the next expected write, with byte_ready low
    always @(negedge clk) begin
        logic [63:0] e;
        if (done) done_cnt++;
        if (imem_we) begin
            chk("ready_low_in_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", imem_addr, e[63:32]);
                chk("write_data", imem_wdata, e[31:0]);
                $display("write addr=%h data=%h", imem_addr, imem_wdata);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
        chk({tag, "_imem_addr"},  imem_addr,       32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_error"},      32'(error),      32'd0);
    endtask

    // Present one byte until accepted, optionally after random idle cycles
    task automatic send_byte(input logic [7:0] b, input bit stall, input bit rnd_start);
        bit acc;
        int n;
        acc = 1'b0;
        if (stall) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                byte_valid = 1'b0;
                start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        byte_valid = 1'b1;
        byte_in = b;
        for (int i = 0; i < 40; i++) begin
            acc = byte_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        byte_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got no accept expected accept of %h", b);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("cpu_hold_rise", 32'(cpu_hold), 32'd1);
        chk("error_cleared", 32'(error), 32'd0);
    endtask

    task automatic fill_random(input int nbytes);
        prog_q.delete();
        repeat (nbytes) prog_q.push_back(8'($urandom));
    endtask

    // One full load: model computes writes and error from the stream rules
    task automatic run_load(input int cnt, input bit stall, input bit bad_ck, input bit rnd_start);
        logic [15:0] c16;
        logic [7:0]  ck;
        bit          oversize;
        bit          exp_err;
        int          d0;
        c16 = 16'(cnt);
        oversize = cnt > CAP;
        ck = 8'd0;
        if (!oversize) begin
            for (int i = 0; i < cnt * 4; i++) ck = ck ^ prog_q[i];
            for (int i = 0; i < cnt; i++)
                exp_q.push_back({32'(i * 4), prog_q[4*i+3], prog_q[4*i+2], prog_q[4*i+1], prog_q[4*i]});
        end
        if (bad_ck) ck = ck ^ 8'h01;
        exp_err = oversize || (CK_EN && bad_ck);

        do_start();
        send_byte(c16[7:0], stall, rnd_start);
        send_byte(c16[15:8], stall, rnd_start);
        if (!oversize) begin
            for (int i = 0; i < cnt * 4; i++) send_byte(prog_q[i], stall, rnd_start);
            if (CK_EN) send_byte(ck, stall, 1'b0);
        end

        d0 = done_cnt;
        for (int i = 0; i < 30 && done_cnt == d0; i++) @(posedge clk);
        #1;
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("done_low_after", 32'(done), 32'd0);
        chk("error_flag", 32'(error), 32'(exp_err));
        chk("cpu_hold_released", 32'(cpu_hold), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("load count=%0d stall=%0d error=%0d", cnt, stall, error);

        if (oversize) begin
            byte_valid = 1'b1;
            byte_in = 8'h5A;
            repeat (3) begin
                chk("no_accept_after_error", 32'(byte_ready), 32'd0);
                @(posedge clk); #1;
            end
            byte_valid = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");

        // Two-word fixed program
        prog_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load(2, 1'b0, 1'b0, 1'b0);

        // Zero-length program
        prog_q.delete();
        run_load(0, 1'b0, 1'b0, 1'b0);

        // Oversize header, then error must clear on the next start
        prog_q.delete();
        run_load(5, 1'b0, 1'b0, 1'b0);

        // Exactly full memory
        fill_random(16);
        run_load(4, 1'b0, 1'b0, 1'b0);

        // Randomized stalls with stray start pulses
        for (int t = 0; t < 6; t++) begin
            fill_random(12);
            run_load(3, 1'b1, 1'b0, 1'b1);
        end

        // Reset after the 6th byte of a two-word load
        fill_random(8);
        exp_q.push_back({32'd0, prog_q[3], prog_q[2], prog_q[1], prog_q[0]});
        do_start();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(prog_q[i], 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        chk("midreset_first_write_seen", 32'(exp_q.size()), 32'd0);
        $display("reset mid-load applied");
        run_load(2, 1'b0, 1'b0, 1'b0);

        // Checksum stream: good then bad trailing byte (plain load without the option)
        prog_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(1, 1'b0, 1'b0, 1'b0);
        run_load(1, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
